// File: rtl/encoder_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder.
//   REQ_W / CODE_W : request vector and code widths
//   RR_RESET_PTR   : round-robin pointer value after reset, so that the
//                    first rotating search starts at index 0
//   code_t         : 3-bit code type
//   state_t        : output register state (IDLE = nothing presented)
//   onehot()       : code -> one-hot request mask
package encoder_pkg;
  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t RR_RESET_PTR = 3'd7;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [REQ_W-1:0] onehot(input code_t c);
    onehot    = '0;
    onehot[c] = 1'b1;
  endfunction
endpackage

// File: rtl/enc8to3_sel.sv
// Combinational selector for the 8-to-3 encoder.
//   vec   : candidate request vector
//   start : first index searched (rotating mode only)
//   idx   : selected index (don't-care when any=0)
//   any   : at least one bit of vec is set
// Build option: ROUND_ROBIN_EN selects a rotating search that begins at
// start and wraps 7 -> 0; otherwise the highest set index wins.
module enc8to3_sel
  import encoder_pkg::*;
(
  input  logic [REQ_W-1:0] vec,
  input  code_t            start,
  output code_t            idx,
  output logic             any
);

`ifdef ROUND_ROBIN_EN
  always_comb begin
    code_t k;
    logic  found;
    idx   = start;
    found = 1'b0;
    k     = start;
    for (int i = 0; i < REQ_W; i++) begin
      // 3-bit addition wraps naturally from 7 back to 0
      k = start + code_t'(i);
      if (!found && vec[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start;

  // Ascending scan: the last hit is the highest set index
  always_comb begin
    idx = '0;
    for (int i = 0; i < REQ_W; i++)
      if (vec[i]) idx = code_t'(i);
  end
`endif

  assign any = |vec;

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ready output handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request lines, OR-ed into the sticky pending set each edge
//   out_ready : consumer takes the presented code this cycle
//   code      : granted index, meaningful while out_valid=1
//   out_valid : a pending request is being presented
//   pending   : sticky request set (includes the presented bit)
// Build option: ROUND_ROBIN_EN enables rotating priority with a last_grant
// pointer; without it the highest index wins and no pointer is built.
module priority_encoder_8to3
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] req,
  input  logic             out_ready,
  output code_t            code,
  output logic             out_valid,
  output logic [REQ_W-1:0] pending
);

  logic [REQ_W-1:0] pending_q, pending_next, clr;
  code_t            code_q, code_next, sel_idx, sel_start;
  state_t           state_q, state_next;
  logic             sel_any, xfer, load;

  assign xfer = (state_q == PRESENT) && out_ready;
  // Output register reloads when empty or when its content is consumed
  assign load = (state_q == IDLE) || xfer;
  assign clr  = xfer ? onehot(code_q) : '0;
  // req applied after clr so a re-request of the granted bit survives
  assign pending_next = (pending_q & ~clr) | req;

`ifdef ROUND_ROBIN_EN
  code_t last_grant_q;

  // On a transfer the pointer is about to become code_q, so search from
  // there already; otherwise continue from the stored pointer.
  assign sel_start = xfer ? code_q + 3'd1 : last_grant_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant_q <= RR_RESET_PTR;
    else if (xfer) last_grant_q <= code_q;
  end
`else
  assign sel_start = '0;
`endif

  enc8to3_sel u_sel (
    .vec   (pending_next),
    .start (sel_start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    state_next = state_q;
    code_next  = code_q;
    if (load) begin
      if (sel_any) begin
        state_next = PRESENT;
        code_next  = sel_idx;
      end else begin
        // nothing left: drop valid, keep the stale code
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      code_q    <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_next;
      code_q    <= code_next;
      state_q   <= state_next;
    end
  end

  assign code      = code_q;
  assign out_valid = (state_q == PRESENT);
  assign pending   = pending_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
module tb_priority_encoder_8to3;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;
  logic [2:0] code;
  logic       out_valid;
  logic [7:0] pending;

  int total = 0;
  int bad   = 0;

  priority_encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .code      (code),
    .out_valid (out_valid),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({pending, out_valid, code} !== {8'h00, 1'b0, 3'd0}) begin
      bad++; $display("FAIL power_on_reset got p=%h v=%b c=%0d want p=00 v=0 c=0", pending, out_valid, code);
    end
    @(negedge clk) rst = 1'b0;
    // build pending=A5 with the consumer stalled
    @(negedge clk) begin req = 8'hA5; out_ready = 1'b0; end
    @(negedge clk) req = 8'h00;
    total++;
    if ({pending, out_valid, code} !== {8'hA5, 1'b1, 3'd7}) begin
      bad++; $display("FAIL pre_reset got p=%h v=%b c=%0d want p=a5 v=1 c=7", pending, out_valid, code);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({pending, out_valid, code} !== {8'h00, 1'b0, 3'd0}) begin
      bad++; $display("FAIL async_reset got p=%h v=%b c=%0d want p=00 v=0 c=0", pending, out_valid, code);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++;
    if ({pending, out_valid, code} !== {8'h00, 1'b0, 3'd0}) begin
      bad++; $display("FAIL post_reset got p=%h v=%b c=%0d want p=00 v=0 c=0", pending, out_valid, code);
    end
  endtask

  task automatic test_single();
    @(negedge clk) begin req = 8'h10; out_ready = 1'b1; end
    @(negedge clk) req = 8'h00;
    total++;
    if ({pending, out_valid, code} !== {8'h10, 1'b1, 3'd4}) begin
      bad++; $display("FAIL single_present got p=%h v=%b c=%0d want p=10 v=1 c=4", pending, out_valid, code);
    end
    @(negedge clk);
    total++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      bad++; $display("FAIL single_drain got p=%h v=%b want p=00 v=0", pending, out_valid);
    end
  endtask

  task automatic test_multi();
    logic [2:0] exp_c [3];
    logic [7:0] exp_p [3];
    exp_c = '{3'd7, 3'd3, 3'd0};
    exp_p = '{8'h89, 8'h09, 8'h01};
    @(negedge clk) begin req = 8'h89; out_ready = 1'b1; end
    @(negedge clk) req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({pending, out_valid, code} !== {exp_p[i], 1'b1, exp_c[i]}) begin
        bad++; $display("FAIL multi_%0d got p=%h v=%b c=%0d want p=%h v=1 c=%0d", i, pending, out_valid, code, exp_p[i], exp_c[i]);
      end
      @(negedge clk);
    end
    total++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      bad++; $display("FAIL multi_drain got p=%h v=%b want p=00 v=0", pending, out_valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk) begin req = 8'h06; out_ready = 1'b0; end
    @(negedge clk) req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({pending, out_valid, code} !== {8'h06, 1'b1, 3'd2}) begin
        bad++; $display("FAIL stall_%0d got p=%h v=%b c=%0d want p=06 v=1 c=2", i, pending, out_valid, code);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({pending, out_valid, code} !== {8'h02, 1'b1, 3'd1}) begin
      bad++; $display("FAIL release_next got p=%h v=%b c=%0d want p=02 v=1 c=1", pending, out_valid, code);
    end
    @(negedge clk);
    total++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      bad++; $display("FAIL release_drain got p=%h v=%b want p=00 v=0", pending, out_valid);
    end
  endtask

  task automatic test_collision();
    @(negedge clk) begin req = 8'h20; out_ready = 1'b1; end
    @(negedge clk);
    total++;
    if ({pending, out_valid, code} !== {8'h20, 1'b1, 3'd5}) begin
      bad++; $display("FAIL collide_first got p=%h v=%b c=%0d want p=20 v=1 c=5", pending, out_valid, code);
    end
    // req=8'h20 still applied during this transfer edge
    @(negedge clk) req = 8'h00;
    total++;
    if ({pending, out_valid, code} !== {8'h20, 1'b1, 3'd5}) begin
      bad++; $display("FAIL collide_again got p=%h v=%b c=%0d want p=20 v=1 c=5", pending, out_valid, code);
    end
    @(negedge clk);
    total++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      bad++; $display("FAIL collide_drain got p=%h v=%b want p=00 v=0", pending, out_valid);
    end
  endtask

  task automatic test_priority_mode();
    logic [2:0] exp_c [4];
`ifdef ROUND_ROBIN_EN
    exp_c = '{3'd0, 3'd7, 3'd0, 3'd7};
`else
    exp_c = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    // fresh pointer so the rotating search starts at 0
    @(negedge clk) rst = 1'b1;
    @(negedge clk) begin rst = 1'b0; req = 8'h81; out_ready = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({pending, out_valid, code} !== {8'h81, 1'b1, exp_c[i]}) begin
        bad++; $display("FAIL mode_%0d got p=%h v=%b c=%0d want p=81 v=1 c=%0d", i, pending, out_valid, code, exp_c[i]);
      end
    end
    req = 8'h00;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({pending, out_valid} !== {8'h00, 1'b0}) begin
      bad++; $display("FAIL mode_drain got p=%h v=%b want p=00 v=0", pending, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_collision();
    test_priority_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
